fft_stage_sequencer: RTL and testbench
======================================

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter N, default 16: FFT length; power of two, at least 4.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of cycles spent in any wait state before an error abort.
REQ-003 Derived constants:
- NSTAGE = log2(N).
- SW = $clog2(N/2), the stage index width.
- TW = $clog2(TIMEOUT+1), the watchdog width.
REQ-004 clk  in  1  single system clock; all logic is on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  request one full FFT run; sampled only in IDLE.
REQ-007 i_abort  in  1  cancel the run in progress; effective in any non-IDLE state.
REQ-008 o_stage  out  SW  current stage index, fed to the coefficient mapper stage input.
REQ-009 o_tw_start  out  1  one-cycle start pulse to the coefficient mapper.
REQ-010 i_tw_dv  in  1  coefficient mapper data-valid (twiddle pass finished).
REQ-011 o_bf_start  out  1  one-cycle start pulse to the butterfly/address engine.
REQ-012 i_bf_done  in  1  butterfly engine finished its N/2 butterflies for this stage.
REQ-013 o_bank  out  1  ping-pong RAM bank select (read bank); the write bank is ~o_bank.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_done  out  1  one-cycle pulse: all NSTAGE stages completed.
REQ-016 o_err  out  1  one-cycle pulse: watchdog expired.

Function
REQ-017 The state machine has states IDLE, TW_START, TW_WAIT, BF_START, BF_WAIT, FIN.
REQ-018 IDLE: when i_start=1, go to TW_START; set stage=0 and bank=0 on the same edge.
REQ-019 TW_START: o_tw_start=1 for exactly this cycle, o_stage is valid; go unconditionally to TW_WAIT.
REQ-020 TW_WAIT: when i_tw_dv=1, go to BF_START; otherwise stay.
REQ-021 BF_START: o_bf_start=1 for exactly this cycle; go unconditionally to BF_WAIT.
REQ-022 BF_WAIT: when i_bf_done=1, the next state depends on the stage:
- stage==NSTAGE-1: go to FIN.
- otherwise: stage+1, bank toggles, go to TW_START.
REQ-023 FIN: o_done=1 for this cycle only, bank toggles, go to IDLE.
REQ-024 i_tw_dv and i_bf_done are ignored outside TW_WAIT and BF_WAIT respectively.
- A stray pulse causes no transition.
- A stray pulse is not latched.
REQ-025 i_start is ignored while o_busy=1; there is no queuing.
REQ-026 i_abort=1 in any non-IDLE state forces IDLE on the next edge:
- no o_done, no o_err;
- stage returns to 0;
- bank is held.
REQ-027 Simultaneous events: i_abort has priority over i_tw_dv, i_bf_done and watchdog expiry.
REQ-028 The watchdog is a TW-bit counter:
- cleared on every entry into TW_WAIT or BF_WAIT;
- increments each cycle the state remains in TW_WAIT or BF_WAIT;
- saturates; never wraps.
REQ-029 Watchdog expiry: when the counter equals TIMEOUT and the awaited input is still 0:
- o_err pulses on the next cycle;
- the state goes to IDLE; stage returns to 0; bank is held.
REQ-030 The awaited input arriving in the same cycle the counter reaches TIMEOUT is accepted as success; there is no error.
REQ-031 o_stage does not change during TW_START through BF_WAIT of a stage; it changes only on the BF_WAIT->TW_START edge.
REQ-032 Minimum run length, with i_tw_dv and i_bf_done high in the first wait cycle: 4*NSTAGE+1 cycles from the first busy cycle to the o_done cycle inclusive.
REQ-033 After a completed run, o_bank = NSTAGE mod 2, so the result sits in bank NSTAGE mod 2.
REQ-034 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-035 rst=1 immediately forces, independent of clk:
- state=IDLE;
- stage=0, bank=0, watchdog=0;
- o_tw_start=0, o_bf_start=0, o_busy=0, o_done=0, o_err=0.
REQ-036 rst asserted mid-run discards the run; no o_done or o_err is generated.
REQ-037 After release, the first i_start is honoured on the first rising edge at which rst=0.

Verification
REQ-038 Nominal run, N=16, responders echo a pulse 1 cycle after each start:
- i_start at cycle 0 -> o_busy high from cycle 1;
- 4 o_tw_start pulses with o_stage 0,1,2,3;
- 4 o_bf_start pulses;
- o_done at cycle 25;
- o_bank=0 afterwards.
REQ-039 Zero-wait run, N=16: i_tw_dv=i_bf_done=1 constantly -> o_done at cycle 17 (16 stage cycles + FIN); o_err never asserted.
REQ-040 Watchdog, TIMEOUT=7: i_tw_dv held 0 after the stage-0 o_tw_start -> o_err pulses exactly once; o_busy=0 next cycle; o_stage=0.
REQ-041 Abort: i_abort asserted in BF_WAIT of stage 2, together with i_bf_done -> IDLE next cycle; no o_done; o_stage=0; a following i_start runs all 4 stages.
REQ-042 Interference: i_start pulses during busy, plus stray i_bf_done during TW_WAIT -> no restart; no stage skip; pulse counts as in REQ-038.
REQ-043 Reset: rst asserted asynchronously mid-cycle in stage 1 -> all outputs 0 before the next edge; o_bank=0; no o_done.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for a radix-2 FFT: walks NSTAGE stages of twiddle-fetch then butterfly pass, ping-ponging the RAM bank.
// All outputs registered (one edge after the deciding input); handshake waits are watchdog-bounded, abort has top priority.
module fft_stage_sequencer #(
    parameter int N       = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    output logic [$clog2(N/2)-1:0]   o_stage,
    output logic                     o_tw_start,
    input  logic                     i_tw_dv,
    output logic                     o_bf_start,
    input  logic                     i_bf_done,
    output logic                     o_bank,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int NSTAGE = $clog2(N);
    localparam int SW     = $clog2(N/2);
    localparam int TW     = $clog2(TIMEOUT+1);

    localparam logic [SW-1:0] LAST_STAGE = SW'(NSTAGE-1);
    localparam logic [TW-1:0] WD_MAX     = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TW_START = 3'd1,
        TW_WAIT  = 3'd2,
        BF_START = 3'd3,
        BF_WAIT  = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            bank_q,  bank_d;
    logic [TW-1:0]   wd_q,    wd_d;
    logic            err_d;
    logic            tw_start_q, bf_start_q, busy_q, done_q, err_q;
    logic            wd_expired;

    assign wd_expired = (wd_q == WD_MAX);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bank_d  = bank_q;
        err_d   = 1'b0;
        wd_d    = '0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = TW_START;
                    stage_d = '0;
                    bank_d  = 1'b0;
                end
            end
            TW_START: state_d = TW_WAIT;
            TW_WAIT: begin
                // A response landing on the expiry cycle still counts as success.
                if (i_tw_dv) begin
                    state_d = BF_START;
                end else if (wd_expired) begin
                    state_d = IDLE;
                    stage_d = '0;
                    err_d   = 1'b1;
                end
            end
            BF_START: state_d = BF_WAIT;
            BF_WAIT: begin
                if (i_bf_done) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = FIN;
                    end else begin
                        state_d = TW_START;
                        stage_d = stage_q + SW'(1);
                        bank_d  = ~bank_q;
                    end
                end else if (wd_expired) begin
                    state_d = IDLE;
                    stage_d = '0;
                    err_d   = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                bank_d  = ~bank_q;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every other outcome; the bank is left where the run stopped.
        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            stage_d = '0;
            bank_d  = bank_q;
            err_d   = 1'b0;
        end

        if ((state_d == state_q) && ((state_q == TW_WAIT) || (state_q == BF_WAIT))) begin
            wd_d = wd_expired ? wd_q : (wd_q + TW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            bank_q     <= 1'b0;
            wd_q       <= '0;
            tw_start_q <= 1'b0;
            bf_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bank_q     <= bank_d;
            wd_q       <= wd_d;
            tw_start_q <= (state_d == TW_START);
            bf_start_q <= (state_d == BF_START);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FIN);
            err_q      <= err_d;
        end
    end

    assign o_stage    = stage_q;
    assign o_bank     = bank_q;
    assign o_tw_start = tw_start_q;
    assign o_bf_start = bf_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised bench for fft_stage_sequencer: a per-run expected timeline is built from stage/response delays.
module tb_fft_stage_sequencer;

    localparam int N       = 16;
    localparam int TIMEOUT = 7;
    localparam int NSTAGE  = $clog2(N);
    localparam int SW      = $clog2(N/2);
    localparam int MAXC    = 256;

    logic          clk = 1'b0;
    logic          rst, i_start, i_abort, i_tw_dv, i_bf_done;
    logic [SW-1:0] o_stage;
    logic          o_tw_start, o_bf_start, o_bank, o_busy, o_done, o_err;

    int n_chk = 0;
    int n_err = 0;

    fft_stage_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .o_stage    (o_stage),
        .o_tw_start (o_tw_start),
        .i_tw_dv    (i_tw_dv),
        .o_bf_start (o_bf_start),
        .i_bf_done  (i_bf_done),
        .o_bank     (o_bank),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    // Expected outputs and planned inputs, indexed by cycle relative to the i_start cycle.
    int e_stage[MAXC], e_tw[MAXC], e_bf[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_bank[MAXC];
    int d_start[MAXC], d_abort[MAXC], d_tw[MAXC], d_bf[MAXC], kind[MAXC];
    int dtw[NSTAGE], dbf[NSTAGE], bf_acc[NSTAGE];
    int last;
    int m_stage = 0;
    int m_bank  = 0;
    int tw_cnt, bf_cnt, done_cnt, err_cnt, done_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic mark(input int c, input int s, input int bank);
        e_stage[c] = s;
        e_bank[c]  = bank;
        e_busy[c]  = 1;
    endtask

    task automatic wait_phase(inout int c, input int s, input int bank, input int d,
                              input int knd, output bit to);
        int n;
        to = (d > TIMEOUT);
        n  = to ? TIMEOUT : d;
        for (int k = 0; k <= n; k++) begin
            mark(c, s, bank);
            kind[c] = knd;
            c++;
        end
        if (!to) begin
            if (knd == 1) d_tw[c-1] = 1;
            else          d_bf[c-1] = 1;
        end
    endtask

    task automatic set_delays(input int tw, input int bf);
        for (int s = 0; s < NSTAGE; s++) begin
            dtw[s] = tw;
            dbf[s] = bf;
        end
    endtask

    task automatic build(input int abort_at, input bit strays, input bit flood);
        int c, bank, end_stage, ab_bank;
        bit to;
        for (int i = 0; i < MAXC; i++) begin
            e_stage[i] = 0; e_tw[i] = 0; e_bf[i] = 0; e_busy[i] = 0;
            e_done[i] = 0;  e_err[i] = 0; e_bank[i] = 0; kind[i] = 0;
            d_start[i] = 0; d_abort[i] = 0; d_tw[i] = int'(flood); d_bf[i] = int'(flood);
        end
        e_stage[0] = m_stage;
        e_bank[0]  = m_bank;
        d_start[0] = 1;
        c = 1; bank = 0; to = 0;
        for (int s = 0; s < NSTAGE; s++) begin
            mark(c, s, bank); e_tw[c] = 1; c++;
            wait_phase(c, s, bank, dtw[s], 1, to);
            if (to) break;
            mark(c, s, bank); e_bf[c] = 1; c++;
            wait_phase(c, s, bank, dbf[s], 2, to);
            if (to) break;
            bf_acc[s] = c - 1;
            if (s == NSTAGE-1) begin
                mark(c, s, bank); e_done[c] = 1; c++;
            end
            bank ^= 1;
        end
        end_stage = to ? 0 : NSTAGE-1;
        e_err[c] = int'(to);
        for (int i = c; i < c + 4; i++) begin
            e_stage[i] = end_stage;
            e_bank[i]  = bank;
        end
        last = c;
        if (strays) begin
            for (int i = 1; i < c; i++) begin
                if (kind[i] != 1 && $urandom_range(2) == 0) d_tw[i] = 1;
                if (kind[i] != 2 && $urandom_range(2) == 0) d_bf[i] = 1;
                if ($urandom_range(3) == 0) d_start[i] = 1;
            end
        end
        if (abort_at > 0 && abort_at < c && e_done[abort_at] == 0) begin
            d_abort[abort_at] = 1;
            ab_bank = e_bank[abort_at];
            for (int i = abort_at + 1; i < MAXC; i++) begin
                e_stage[i] = 0; e_tw[i] = 0; e_bf[i] = 0; e_busy[i] = 0;
                e_done[i] = 0;  e_err[i] = 0; e_bank[i] = ab_bank;
                d_start[i] = 0; d_abort[i] = 0; d_tw[i] = int'(flood); d_bf[i] = int'(flood);
            end
            last = abort_at + 1;
        end
    endtask

    task automatic check_cycle(input int t);
        check("stage",    o_stage,    e_stage[t]);
        check("tw_start", o_tw_start, e_tw[t]);
        check("bf_start", o_bf_start, e_bf[t]);
        check("busy",     o_busy,     e_busy[t]);
        check("done",     o_done,     e_done[t]);
        check("err",      o_err,      e_err[t]);
        check("bank",     o_bank,     e_bank[t]);
    endtask

    // Entered #1 after an edge; that cycle is cycle 0. rst_at >= 0 fires an async reset mid-cycle.
    task automatic run_trace(input int rst_at);
        tw_cnt = 0; bf_cnt = 0; done_cnt = 0; err_cnt = 0; done_t = -1;
        for (int t = 0; t <= last + 3; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (o_tw_start === 1'b1) tw_cnt++;
            if (o_bf_start === 1'b1) bf_cnt++;
            if (o_err === 1'b1)      err_cnt++;
            if (o_done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            check_cycle(t);
            i_start   = (d_start[t] != 0);
            i_abort   = (d_abort[t] != 0);
            i_tw_dv   = (d_tw[t] != 0);
            i_bf_done = (d_bf[t] != 0);
            if (t == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_stage", o_stage, 0);
                check("rst_tw",    o_tw_start, 0);
                check("rst_bf",    o_bf_start, 0);
                check("rst_busy",  o_busy, 0);
                check("rst_done",  o_done, 0);
                check("rst_err",   o_err, 0);
                check("rst_bank",  o_bank, 0);
                @(posedge clk);
                #1;
                if (o_done === 1'b1) done_cnt++;
                rst = 1'b0;
                i_start = 0; i_abort = 0; i_tw_dv = 0; i_bf_done = 0;
                m_stage = 0;
                m_bank  = 0;
                return;
            end
        end
        i_start = 0; i_abort = 0; i_tw_dv = 0; i_bf_done = 0;
        m_stage = e_stage[last+3];
        m_bank  = e_bank[last+3];
    endtask

    initial begin
        int ab;
        rst = 1'b1; i_start = 0; i_abort = 0; i_tw_dv = 0; i_bf_done = 0;
        #1;
        check("reset_busy",  o_busy, 0);
        check("reset_stage", o_stage, 0);
        check("reset_bank",  o_bank, 0);
        check("reset_err",   o_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal: responders answer in the second wait cycle.
        set_delays(1, 1); build(0, 0, 0); run_trace(-1);
        check("nom_tw_pulses", tw_cnt, NSTAGE);
        check("nom_bf_pulses", bf_cnt, NSTAGE);
        check("nom_done_cycle", done_t, 25);
        check("nom_final_bank", o_bank, NSTAGE % 2);

        // Zero-wait: both responses held high throughout.
        set_delays(0, 0); build(0, 0, 1); run_trace(-1);
        check("zw_done_cycle", done_t, 17);
        check("zw_err_pulses", err_cnt, 0);

        // Watchdog expiry in stage 0 twiddle wait.
        set_delays(1, 1); dtw[0] = TIMEOUT + 3; build(0, 0, 0); run_trace(-1);
        check("wd_err_pulses", err_cnt, 1);
        check("wd_done_pulses", done_cnt, 0);
        check("wd_stage", o_stage, 0);

        // Response on the expiry cycle is success.
        set_delays(0, 0); dbf[1] = TIMEOUT; build(0, 0, 0); run_trace(-1);
        check("wd_edge_err", err_cnt, 0);
        check("wd_edge_done", done_cnt, 1);

        // Abort together with bf_done in stage 2, then a full run.
        set_delays(1, 1); build(0, 0, 0); ab = bf_acc[2];
        build(ab, 0, 0); run_trace(-1);
        check("abort_done_pulses", done_cnt, 0);
        check("abort_stage", o_stage, 0);
        set_delays(1, 1); build(0, 0, 0); run_trace(-1);
        check("post_abort_tw", tw_cnt, NSTAGE);
        check("post_abort_done", done_cnt, 1);

        // Interference: stray starts and responses outside their wait states.
        set_delays(1, 1); build(0, 1, 0); run_trace(-1);
        check("intf_tw_pulses", tw_cnt, NSTAGE);
        check("intf_bf_pulses", bf_cnt, NSTAGE);
        check("intf_done_cycle", done_t, 25);

        // Async reset in stage 1, then an immediate start.
        set_delays(1, 1); build(0, 0, 0); run_trace(8);
        check("rst_no_done", done_cnt, 0);
        set_delays(1, 1); build(0, 0, 0); run_trace(-1);
        check("post_rst_done_cycle", done_t, 25);

        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < NSTAGE; s++) begin
                case ($urandom_range(9))
                    0:       dtw[s] = TIMEOUT + 1 + int'($urandom_range(2));
                    1:       dtw[s] = TIMEOUT;
                    default: dtw[s] = int'($urandom_range(3));
                endcase
                case ($urandom_range(9))
                    0:       dbf[s] = TIMEOUT + 1 + int'($urandom_range(2));
                    1:       dbf[s] = TIMEOUT;
                    default: dbf[s] = int'($urandom_range(3));
                endcase
            end
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(60, 1)) : 0;
            build(ab, $urandom_range(1) == 1, 1'b0);
            run_trace(-1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
